// File: rtl/rgb_pwm_cmd.sv
// UART-commanded three-channel 8-bit PWM with per-channel shadow/active duty and one-byte ack.
// Optional macro RGB_PWM_GAMMA_EN applies a square-law curve to the comparator threshold.
module rgb_pwm_cmd #(
    parameter int unsigned PRESCALE     = 47,
    parameter logic [7:0]  DEFAULT_DUTY = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       ack_valid,
    output logic [7:0] ack_data,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       pwm_r,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b
);

    localparam int unsigned PRE_W   = 16;
    localparam logic [7:0]  CH_R    = 8'h52;
    localparam logic [7:0]  CH_G    = 8'h47;
    localparam logic [7:0]  CH_B    = 8'h42;
    localparam logic [7:0]  ASC_CR  = 8'h0D;
    localparam logic [7:0]  ASC_LF  = 8'h0A;
    localparam logic [7:0]  ACK_OK  = 8'h4B;
    localparam logic [7:0]  ACK_ERR = 8'h3F;

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_CR} state_t;

    state_t           state, state_nx;
    logic [1:0]       chan;
    logic [3:0]       hi_nib, lo_nib;
    logic [PRE_W-1:0] presc;
    logic [7:0]       pwm_cnt;
    logic [7:0]       act_r, act_g, act_b;

    logic       is_hex_c, is_chan_c, commit_c, error_c, tick_c;
    logic [3:0] hex_val_c;
    logic [1:0] chan_c;

    function automatic logic [7:0] shape(input logic [7:0] a);
`ifdef RGB_PWM_GAMMA_EN
        return 8'((16'(a) * 16'(a)) >> 8);
`else
        return a;
`endif
    endfunction

    // Byte classification: hex digit value and channel index
    always_comb begin
        is_hex_c  = 1'b0;
        hex_val_c = 4'd0;
        is_chan_c = 1'b0;
        chan_c    = 2'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex_c  = 1'b1;
            hex_val_c = 4'(rx_data - 8'h30);
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_hex_c  = 1'b1;
            hex_val_c = 4'(rx_data - 8'h37);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_hex_c  = 1'b1;
            hex_val_c = 4'(rx_data - 8'h57);
        end
        case (rx_data)
            CH_R:    begin is_chan_c = 1'b1; chan_c = 2'd0; end
            CH_G:    begin is_chan_c = 1'b1; chan_c = 2'd1; end
            CH_B:    begin is_chan_c = 1'b1; chan_c = 2'd2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Command parser next-state and commit/error strobes
    always_comb begin
        state_nx = state;
        commit_c = 1'b0;
        error_c  = 1'b0;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_chan_c)                                state_nx = S_HI;
                    else if (rx_data != ASC_CR && rx_data != ASC_LF) error_c = 1'b1;
                end
                S_HI: begin
                    if (is_hex_c) state_nx = S_LO;
                    else begin error_c = 1'b1; state_nx = S_IDLE; end
                end
                S_LO: begin
                    if (is_hex_c) state_nx = S_CR;
                    else begin error_c = 1'b1; state_nx = S_IDLE; end
                end
                S_CR: begin
                    state_nx = S_IDLE;
                    if (rx_data == ASC_CR) commit_c = 1'b1;
                    else                   error_c  = 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Command fields and shadow duty registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan   <= 2'd0;
            hi_nib <= 4'd0;
            lo_nib <= 4'd0;
            duty_r <= DEFAULT_DUTY;
            duty_g <= DEFAULT_DUTY;
            duty_b <= DEFAULT_DUTY;
        end else begin
            if (rx_valid && state == S_IDLE && is_chan_c) chan   <= chan_c;
            if (rx_valid && state == S_HI && is_hex_c)    hi_nib <= hex_val_c;
            if (rx_valid && state == S_LO && is_hex_c)    lo_nib <= hex_val_c;
            if (commit_c) begin
                case (chan)
                    2'd0:    duty_r <= {hi_nib, lo_nib};
                    2'd1:    duty_g <= {hi_nib, lo_nib};
                    2'd2:    duty_b <= {hi_nib, lo_nib};
                    default: ;
                endcase
            end
        end
    end

    // Single-entry ack holder; responses arriving while one is pending are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
        end else if (ack_valid) begin
            if (!tx_busy) ack_valid <= 1'b0;
        end else if (commit_c || error_c) begin
            ack_valid <= 1'b1;
            ack_data  <= commit_c ? ACK_OK : ACK_ERR;
        end
    end

    assign tick_c = (presc == PRE_W'(PRESCALE - 1));

    // Timebase, period-boundary duty transfer and registered comparators
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            pwm_cnt <= 8'd0;
            act_r   <= DEFAULT_DUTY;
            act_g   <= DEFAULT_DUTY;
            act_b   <= DEFAULT_DUTY;
            pwm_r   <= 1'b0;
            pwm_g   <= 1'b0;
            pwm_b   <= 1'b0;
        end else begin
            presc <= tick_c ? '0 : presc + 1'b1;
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + 8'd1;
                if (pwm_cnt == 8'hFF) begin
                    act_r <= duty_r;
                    act_g <= duty_g;
                    act_b <= duty_b;
                end
            end
            pwm_r <= (pwm_cnt < shape(act_r));
            pwm_g <= (pwm_cnt < shape(act_g));
            pwm_b <= (pwm_cnt < shape(act_b));
        end
    end

endmodule

// File: tb/tb_rgb_pwm_cmd.sv
// Directed bench for rgb_pwm_cmd: command parsing, ack handshake, PWM duty and async reset.
module tb_rgb_pwm_cmd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       ack_valid;
    logic [7:0] ack_data;
    logic       pwm_g, pwm_b, pwm_r;
    logic [7:0] duty_r, duty_g, duty_b;

    int errors = 0;
    int checks = 0;

`ifdef RGB_PWM_GAMMA_EN
    localparam int EXP_80 = 64;
    localparam int EXP_FF = 254;
`else
    localparam int EXP_80 = 128;
    localparam int EXP_FF = 255;
`endif

    rgb_pwm_cmd #(.PRESCALE(1), .DEFAULT_DUTY(8'h00)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .ack_valid(ack_valid), .ack_data(ack_data),
        .pwm_g(pwm_g), .pwm_b(pwm_b), .pwm_r(pwm_r),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte presented for exactly one rising edge; returns at the negedge after it
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Sum of high samples of channel ch (0=r,1=g,2=b) over n clocks
    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (ch)
                0:       cnt += int'(pwm_r);
                1:       cnt += int'(pwm_g);
                default: cnt += int'(pwm_b);
            endcase
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c, c2, c3;
        bit seen;

        // Reset state
        skip(3);
        reset = 1'b0;
        check("rst_duty_r", 32'(duty_r), 32'h00);
        check("rst_duty_g", 32'(duty_g), 32'h00);
        check("rst_duty_b", 32'(duty_b), 32'h00);
        check("rst_ack_valid", 32'(ack_valid), 0);
        check("rst_ack_data", 32'(ack_data), 32'h00);
        count_high(0, 1024, c);
        count_high(1, 1024, c2);
        count_high(2, 1024, c3);
        check("rst_pwm_all_low", 32'(c + c2 + c3), 0);

        // R80 commit, single-cycle ack, half duty
        send(8'h52); send(8'h38); send(8'h30);
        check("r80_no_ack_before_cr", 32'(ack_valid), 0);
        send(8'h0D);
        check("r80_ack_valid", 32'(ack_valid), 1);
        check("r80_ack_data", 32'(ack_data), 32'h4B);
        check("r80_duty_r", 32'(duty_r), 32'h80);
        @(negedge clk);
        check("r80_ack_dropped", 32'(ack_valid), 0);
        skip(300);
        count_high(0, 256, c);
        check("r80_pwm_r_high", 32'(c), 32'(EXP_80));

        // GfF full duty, then G00 off
        send(8'h47); send(8'h66); send(8'h46); send(8'h0D);
        check("gff_ack_data", 32'(ack_data), 32'h4B);
        check("gff_duty_g", 32'(duty_g), 32'hFF);
        skip(300);
        count_high(1, 256, c);
        check("gff_pwm_g_high", 32'(c), 32'(EXP_FF));
        send(8'h47); send(8'h30); send(8'h30); send(8'h0D);
        check("g00_duty_g", 32'(duty_g), 32'h00);
        skip(300);
        count_high(1, 512, c);
        check("g00_pwm_g_high", 32'(c), 0);

        // LF ignored in IDLE, lowercase channel letter rejected
        send(8'h0A);
        check("lf_ignored", 32'(ack_valid), 0);
        send(8'h72);
        check("lower_r_ack_valid", 32'(ack_valid), 1);
        check("lower_r_ack_data", 32'(ack_data), 32'h3F);
        @(negedge clk);

        // B4X error then B40 commit
        send(8'h42); send(8'h34); send(8'h58);
        check("b4x_ack_valid", 32'(ack_valid), 1);
        check("b4x_ack_data", 32'(ack_data), 32'h3F);
        check("b4x_duty_b", 32'(duty_b), 32'h00);
        @(negedge clk);
        send(8'h42); send(8'h34); send(8'h30); send(8'h0D);
        check("b40_ack_data", 32'(ack_data), 32'h4B);
        check("b40_duty_b", 32'(duty_b), 32'h40);
        @(negedge clk);

        // Ack held while tx_busy; a second response is dropped
        tx_busy = 1'b1;
        send(8'h47); send(8'h31); send(8'h32); send(8'h0D);
        check("busy_ack_data", 32'(ack_data), 32'h4B);
        check("busy_duty_g", 32'(duty_g), 32'h12);
        skip(10);
        send(8'h5A);
        check("busy_err_dropped", 32'(ack_data), 32'h4B);
        skip(30);
        check("busy_ack_held", 32'(ack_valid), 1);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_consumed", 32'(ack_valid), 0);

        // Reset mid-command during a high pwm_r phase
        send(8'h52); send(8'h31);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (pwm_r) seen = 1'b1;
        end
        check("pre_reset_pwm_r_seen", 32'(seen), 1);
        reset = 1'b1;
        #1;
        check("async_rst_pwm_r", 32'(pwm_r), 0);
        check("async_rst_duty_r", 32'(duty_r), 32'h00);
        check("async_rst_duty_g", 32'(duty_g), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        send(8'h32);
        check("post_rst_2_ack_valid", 32'(ack_valid), 1);
        check("post_rst_2_ack_data", 32'(ack_data), 32'h3F);
        send(8'h0D);
        check("post_rst_cr_no_ack", 32'(ack_valid), 0);
        check("post_rst_duty_r", 32'(duty_r), 32'h00);
        count_high(0, 600, c);
        check("post_rst_pwm_r_low", 32'(c), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
